// File: rtl/fifo_stream_arbiter_pkg.sv
// Shared types and helpers for fifo_stream_arbiter.
// The optional statistics counters are enabled by defining FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } arb_state_t;

    localparam int STAT_W  = 32;

    // rr_pick is written for at most MAX_REQ producers.
    localparam int MAX_REQ = 32;
    localparam int IDX_W   = 5;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid[n-1:0], scanning upward from ptr and wrapping at n.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [IDX_W-1:0]   ptr,
                                         input int                 n);
        rr_pick_t res;
        int       i;
        res = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            i = int'(ptr) + k;
            if (i >= n) i = i - n;
            if (k < n && !res.found && valid[IDX_W'(i)]) begin
                res.found = 1'b1;
                res.idx   = IDX_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_stream_arbiter_rr.sv
// Round-robin arbiter: one-hot grant plus binary index of the winner.
// The search starts at ptr; enable low suppresses any grant.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            found
);

    rr_pick_t pick;

    // Pick the winner and expand it to a one-hot grant.
    always_comb begin
        pick  = rr_pick(MAX_REQ'(valid), IDX_W'(ptr), NREQ);
        found = enable && pick.found;
        idx   = IDW'(pick.idx);
        grant = '0;
        if (found) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/fifo_stream_arbiter.sv
// fifo_stream_arbiter: NREQ valid/ready producers share one external FIFO.
// Write side tags each word with its producer id; read side hides the FIFO's
// registered-dout latency behind a 2-entry skid buffer for full throughput.
// A flush request drains and discards everything between layers.
// Define FIFO_ARB_STATS_EN to add the grant_cnt / stall_cnt counters.
module fifo_stream_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int WIDTH = 256,
    parameter  int NREQ  = 4,
    localparam int IDW   = $clog2(NREQ),
    localparam int FW    = IDW + WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [IDW-1:0]        out_src,
    input  logic                  flush,
    output logic                  flush_done,
    output logic                  busy,
    output logic                  fifo_push,
    output logic [FW-1:0]         fifo_din,
    output logic                  fifo_pop,
    input  logic [FW-1:0]         fifo_dout,
    input  logic                  fifo_full,
    input  logic                  fifo_empty
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NREQ*STAT_W-1:0] grant_cnt,
    output logic [STAT_W-1:0]      stall_cnt
`endif
);

    arb_state_t      state, state_nx;
    logic [IDW-1:0]  ptr;
    logic            grant_en, grant_found;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;

    logic [FW-1:0]   skid [2];
    logic [1:0]      skid_cnt, skid_after;
    logic            inflight, skid_wr, deq, flush_go;
    logic [1:0]      occ, occ_after;

    // ---------------- write side ----------------
    // Only arbitrate while running and the FIFO reports space.
    always_comb grant_en = !reset && state == RUN && !fifo_full;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .valid  (req_valid),
        .ptr    (ptr),
        .enable (grant_en),
        .grant  (grant),
        .idx    (grant_idx),
        .found  (grant_found)
    );

    assign req_ready = grant;
    assign fifo_push = grant_found;
    assign fifo_din  = {grant_idx, req_data[int'(grant_idx)*WIDTH +: WIDTH]};

    // Pointer moves past the winner; flush completion restarts it at 0.
    always_ff @(posedge clk) begin
        if (reset || flush_done)
            ptr <= '0;
        else if (grant_found)
            ptr <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
    end

    // ---------------- read side ----------------
    assign out_valid = !reset && state == RUN && skid_cnt != 2'd0;
    assign out_data  = skid[0][WIDTH-1:0];
    assign out_src   = skid[0][FW-1 -: IDW];
    assign deq       = out_valid && out_ready;

    // FSM next state, pop decision and status pulses.
    always_comb begin
        state_nx   = state;
        flush_done = 1'b0;
        busy       = 1'b0;
        fifo_pop   = 1'b0;
        flush_go   = 1'b0;
        occ        = skid_cnt + {1'b0, inflight};
        occ_after  = occ - {1'b0, deq};
        case (state)
            RUN: begin
                // Pop only if the word will have a skid slot when it lands.
                fifo_pop = !fifo_empty && (occ_after < 2'd2);
                if (flush) begin
                    state_nx = FLUSH;
                    flush_go = 1'b1;
                end
            end
            FLUSH: begin
                busy     = 1'b1;
                fifo_pop = !fifo_empty;
                if (fifo_empty && !inflight) begin
                    flush_done = 1'b1;
                    state_nx   = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
        if (reset) begin
            fifo_pop   = 1'b0;
            flush_done = 1'b0;
            busy       = 1'b0;
            flush_go   = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_nx;
    end

    // A pop this cycle means fifo_dout carries a word next cycle.
    always_ff @(posedge clk) begin
        if (reset) inflight <= 1'b0;
        else       inflight <= fifo_pop;
    end

    // Words arriving while flushing are dropped instead of captured.
    always_comb begin
        skid_wr    = inflight && state == RUN && !flush_go;
        skid_after = skid_cnt - {1'b0, deq};
    end

    // Skid buffer: entry 0 is the head; dequeue shifts, arrivals append.
    always_ff @(posedge clk) begin
        if (reset || flush_go || state == FLUSH) begin
            skid_cnt <= 2'd0;
            skid[0]  <= '0;
            skid[1]  <= '0;
        end else begin
            if (deq)     skid[0] <= skid[1];
            if (skid_wr) skid[skid_after[0]] <= fifo_dout;
            skid_cnt <= skid_after + {1'b0, skid_wr};
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [NREQ-1:0][STAT_W-1:0] gcnt;
    logic [STAT_W-1:0]           scnt;

    // Per-producer accepted words and full-stall cycles; cleared by flush.
    always_ff @(posedge clk) begin
        if (reset || flush_done) begin
            gcnt <= '0;
            scnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (grant[i]) gcnt[i] <= gcnt[i] + 1'b1;
            if (|req_valid && fifo_full) scnt <= scnt + 1'b1;
        end
    end

    assign grant_cnt = gcnt;
    assign stall_cnt = scnt;
`endif

endmodule

// File: tb/tb_fifo_stream_arbiter.sv
// Randomized bench for fifo_stream_arbiter with a queue-based FIFO model and
// a transaction-level reference (arbitration order, word scoreboard, occupancy).
// Stats checks are compiled in when FIFO_ARB_STATS_EN is defined.
module tb_fifo_stream_arbiter;
    import fifo_arb_pkg::*;

    localparam int WIDTH = 256;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int FW    = IDW + WIDTH;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [WIDTH-1:0]      out_data;
    logic [IDW-1:0]        out_src;
    logic                  flush = 1'b0;
    logic                  flush_done, busy;
    logic                  fifo_push, fifo_pop;
    logic [FW-1:0]         fifo_din;
    logic [FW-1:0]         fifo_dout;
    logic                  fifo_full, fifo_empty;
`ifdef FIFO_ARB_STATS_EN
    logic [NREQ*32-1:0]    grant_cnt;
    logic [31:0]           stall_cnt;
`endif

    always #5 clk = ~clk;

    fifo_stream_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
        .flush(flush), .flush_done(flush_done), .busy(busy),
        .fifo_push(fifo_push), .fifo_din(fifo_din), .fifo_pop(fifo_pop),
        .fifo_dout(fifo_dout), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
`ifdef FIFO_ARB_STATS_EN
        , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
    );

    // ---------------- external FIFO model ----------------
    logic [FW-1:0] fq [$];
    int            fcnt = 0;
    int            fifo_depth = 16;

    assign fifo_full  = (fcnt >= fifo_depth);
    assign fifo_empty = (fcnt == 0);

    always @(posedge clk) begin
        if (reset) begin
            fq.delete();
            fcnt      <= 0;
            fifo_dout <= '0;
        end else begin
            if (fifo_pop && fq.size() > 0) fifo_dout <= fq.pop_front();
            if (fifo_push && fcnt < fifo_depth) fq.push_back(fifo_din);
            fcnt <= fq.size();
        end
    end

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- producers and reference model ----------------
    logic [NREQ-1:0]  cur_v = '0;
    logic [WIDTH-1:0] cur_d [NREQ];
    logic [NREQ-1:0]  gen_en = '0;
    int unsigned      gen_pct = 100;
    int               rdy_mode = 1;   // 0 random, 1 always, 2 never, 3 toggle

    int            m_ptr = 0;
    bit            m_flush = 0;
    int            m_occ = 0;         // words popped from FIFO, not yet delivered
    bit            m_inflight = 0;
    logic [FW-1:0] sb [$];
    int            m_gcnt [NREQ];
    int            m_stall = 0;

    int cyc = 0, deliv = 0, npush = 0, ndone_obs = 0;
    int t_push = -1, t_ov = -1;
    int glog [$];

    function automatic logic [WIDTH-1:0] rand_word();
        logic [WIDTH-1:0] w;
        for (int k = 0; k < WIDTH/32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic model_clear();
        cur_v = '0; m_ptr = 0; m_flush = 0; m_occ = 0; m_inflight = 0;
        sb.delete(); m_stall = 0;
        for (int i = 0; i < NREQ; i++) m_gcnt[i] = 0;
    endtask

    // One clock: drive inputs, check every output against the model, advance.
    task automatic cycle(input bit fl);
        logic [NREQ-1:0] exp_ready;
        logic [FW-1:0]   w;
        int              g, skidn, idx;
        bit              exp_ov, deq, exp_pop, exp_done;
        for (int i = 0; i < NREQ; i++)
            if (!cur_v[i] && gen_en[i] && $urandom_range(99) < gen_pct) begin
                cur_v[i] = 1'b1;
                cur_d[i] = rand_word();
            end
        req_valid = cur_v;
        for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = cur_d[i];
        case (rdy_mode)
            0:       out_ready = 1'($urandom_range(1));
            1:       out_ready = 1'b1;
            2:       out_ready = 1'b0;
            default: out_ready = cyc[0];
        endcase
        flush = fl;
        #2;
        // Arbitration: first valid producer at or after the pointer.
        exp_ready = '0; g = -1; w = '0;
        if (!m_flush && !fifo_full)
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (g < 0 && cur_v[idx]) g = idx;
            end
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", 512'(req_ready), 512'(exp_ready));
        chk("fifo_push", 512'(fifo_push), 512'(g >= 0));
        if (g >= 0) begin
            w = {IDW'(g), cur_d[g]};
            chk("fifo_din", 512'(fifo_din), 512'(w));
        end
        // Output stream: head of scoreboard whenever a word sits in the skid.
        skidn  = m_occ - int'(m_inflight);
        exp_ov = !m_flush && skidn > 0;
        chk("out_valid", 512'(out_valid), 512'(exp_ov));
        deq = 1'b0;
        if (exp_ov) begin
            if (sb.size() > 0) begin
                chk("out_word", 512'({out_src, out_data}), 512'(sb[0]));
                deq = out_ready;
            end else
                chk("out_unexpected", 512'(out_valid), 512'(0));
        end
        exp_pop  = m_flush ? !fifo_empty : (!fifo_empty && (m_occ - int'(deq)) < 2);
        exp_done = m_flush && fifo_empty && !m_inflight;
        chk("fifo_pop", 512'(fifo_pop), 512'(exp_pop));
        chk("flush_done", 512'(flush_done), 512'(exp_done));
        chk("busy", 512'(busy), 512'(m_flush));
        if (flush_done) ndone_obs++;
`ifdef FIFO_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++)
            chk("grant_cnt", 512'(grant_cnt[i*32 +: 32]), 512'(32'(m_gcnt[i])));
        chk("stall_cnt", 512'(stall_cnt), 512'(32'(m_stall)));
`endif
        // Advance the reference.
        if (deq) begin
            void'(sb.pop_front());
            deliv++;
        end
        if (g >= 0) begin
            sb.push_back(w);
            cur_v[g] = 1'b0;
            m_ptr = (g + 1) % NREQ;
            m_gcnt[g]++;
            npush++;
            glog.push_back(g);
            if (t_push < 0) t_push = cyc;
        end
        if (exp_ov && t_ov < 0) t_ov = cyc;
        if (|req_valid && fifo_full) m_stall++;
        if (!m_flush) m_occ = m_occ - int'(deq) + int'(exp_pop);
        m_inflight = exp_pop;
        if (exp_done) begin
            m_flush = 0; m_ptr = 0; m_stall = 0;
            for (int i = 0; i < NREQ; i++) m_gcnt[i] = 0;
        end else if (!m_flush && fl) begin
            m_flush = 1; m_occ = 0; sb.delete();
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = '1; out_ready = 1'b1; flush = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        chk("rst_req_ready", 512'(req_ready), 512'(0));
        chk("rst_push", 512'(fifo_push), 512'(0));
        chk("rst_pop", 512'(fifo_pop), 512'(0));
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_out_word", 512'({out_src, out_data}), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_flush_done", 512'(flush_done), 512'(0));
`ifdef FIFO_ARB_STATS_EN
        chk("rst_stats", 512'({grant_cnt, stall_cnt}), 512'(0));
`endif
        reset = 1'b0; req_valid = '0;
        model_clear();
    endtask

    task automatic drain(input int n);
        gen_en = '0; cur_v = '0; rdy_mode = 1;
        repeat (n) cycle(0);
    endtask

    task automatic wait_flush();
        for (int k = 0; k < 30 && m_flush; k++) cycle(0);
        if (m_flush) chk("flush_timeout", 512'(busy), 512'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0, d0;
        for (int i = 0; i < NREQ; i++) cur_d[i] = '0;
        do_reset();

        // All producers valid: strict rotation 0,1,2,3,0,1,2,3.
        fifo_depth = 16; gen_en = '1; gen_pct = 100; rdy_mode = 1; glog.delete();
        repeat (8) cycle(0);
        chk("t1_ngrants", 512'(glog.size()), 512'(8));
        for (int k = 0; k < glog.size(); k++) chk("t1_grant", 512'(glog[k]), 512'(k % 4));
        drain(12);

        // Single producer streams at one word per cycle; 3-cycle latency.
        gen_en = 4'b0100; t_push = -1; t_ov = -1; n0 = npush;
        repeat (10) cycle(0);
        chk("t2_accepts", 512'(npush - n0), 512'(10));
        chk("t2_latency", 512'(t_ov - t_push), 512'(3));
        drain(12);

        // Depth-4 FIFO, consumer stalled: 4 in FIFO + 2 in skid, no more pops.
        fifo_depth = 4; gen_en = '1; rdy_mode = 2; n0 = npush;
        repeat (12) cycle(0);
        chk("t3_pushes", 512'(npush - n0), 512'(6));
        chk("t3_pop_idle", 512'(fifo_pop), 512'(0));
        chk("t3_out_valid", 512'(out_valid), 512'(1));
        d0 = deliv;
        drain(12);
        chk("t3_delivered", 512'(deliv - d0), 512'(6));
        fifo_depth = 16;

        // Full load with out_ready toggling.
        gen_en = '1; rdy_mode = 3; d0 = deliv; n0 = npush;
        repeat (40) cycle(0);
        drain(20);
        chk("t4_no_loss", 512'(deliv - d0), 512'(npush - n0));

        // Queue words with a stalled consumer, flush, then resume.
        gen_en = 4'b0001; rdy_mode = 2;
        repeat (5) cycle(0);
        gen_en = '0; cur_v = '0;
        repeat (4) cycle(0);
        chk("t5_valid_before", 512'(out_valid), 512'(1));
        d0 = ndone_obs;
        cycle(1);
        chk("t5_out_valid_flush", 512'(out_valid), 512'(0));
        wait_flush();
        chk("t5_done_pulses", 512'(ndone_obs - d0), 512'(1));
        rdy_mode = 1; gen_en = 4'b1000;
        cycle(0);
        gen_en = '0; d0 = deliv;
        repeat (6) cycle(0);
        chk("t5_after_flush", 512'(deliv - d0), 512'(1));

`ifdef FIFO_ARB_STATS_EN
        // 5 grants to producer 1, then 3 stall cycles against a full FIFO.
        gen_en = 4'b0010; gen_pct = 100;
        repeat (5) cycle(0);
        fifo_depth = 0;
        repeat (3) cycle(0);
        chk("t6_grant1", 512'(grant_cnt[63:32]), 512'(5));
        chk("t6_stall", 512'(stall_cnt), 512'(3));
        fifo_depth = 16;
        drain(10);
        cycle(1);
        wait_flush();
        chk("t6_cleared", 512'({grant_cnt, stall_cnt}), 512'(0));
`endif

        // Random traffic with flushes, depth changes and a mid-stream reset.
        for (int it = 0; it < 900; it++) begin
            if (it % 100 == 0) begin
                fifo_depth = int'($urandom_range(8, 1));
                rdy_mode   = (it % 200 == 0) ? 0 : int'($urandom_range(3));
                gen_en     = NREQ'($urandom_range(15, 1));
                gen_pct    = $urandom_range(100, 20);
            end
            if (it == 450) do_reset();
            cycle(!m_flush && $urandom_range(59) == 0);
        end
        fifo_depth = 16;
        drain(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
